// File: rtl/crazyballoon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crazyballoon_pkg
//  Description : Shared types and constants for the ioctl download sequencer.
//                Holds the sequencer state enum and the hps_io ioctl_index
//                values that carry ROM and DIP-switch data.
//  Revision    : 1.0  initial release
// ============================================================================
package crazyballoon_pkg;

    // Download sequencer states.
    typedef enum logic [2:0] {
        WAIT_ROM = 3'd0,    // no valid ROM image yet, core held in reset
        ROM_LOAD = 3'd1,    // ROM bytes streaming to the core
        DIP_LOAD = 3'd2,    // DIP bytes streaming into the switch bank
        SETTLE   = 3'd3,    // reset-hold period after a download or user reset
        RUN      = 3'd4     // core released from reset
    } load_state_t;

    // ioctl_index values used by hps_io for this core.
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_DIP = 8'd254;

    // True for the two states that consume ioctl_wr strobes.
    function automatic logic is_load_state(input load_state_t s);
        return (s == ROM_LOAD) || (s == DIP_LOAD);
    endfunction

endpackage : crazyballoon_pkg
`default_nettype wire

// File: rtl/ioctl_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ioctl_load_ctrl_if
//  Description : hps_io ioctl download bus.
//                master : hps_io side, drives every signal
//                slave  : download sequencer side, samples every signal
//  Signals     : ioctl_download  download in progress
//                ioctl_wr        one-cycle strobe marking a valid byte
//                ioctl_index     download index
//                ioctl_addr      byte address within the download
//                ioctl_dout      data byte
//  Revision    : 1.0  initial release
// ============================================================================
interface ioctl_load_ctrl_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (
        output ioctl_download,
        output ioctl_wr,
        output ioctl_index,
        output ioctl_addr,
        output ioctl_dout
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_wr,
        input  ioctl_index,
        input  ioctl_addr,
        input  ioctl_dout
    );

endinterface : ioctl_load_ctrl_if
`default_nettype wire

// File: rtl/reset_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : reset_stretch
//  Description : Reset-hold down-counter. A start pulse loads CYCLES-1; the
//                counter then decrements once per clock until it reaches 0.
//                busy is high while the count is non-zero, so a start seen
//                before edge n lets the owner leave its hold state at edge
//                n+CYCLES. A start while busy reloads the count.
//  Ports       : CLK      system clock, rising edge
//                RESET_N  asynchronous active-low reset
//                start    load the counter with CYCLES-1
//                busy     count not yet exhausted
//  Revision    : 1.0  initial release
// ============================================================================
module reset_stretch #(
    parameter int CYCLES = 1024
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic start,
    output logic busy
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (start) begin
            count <= CW'(CYCLES - 1);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign busy = (count != '0);

endmodule : reset_stretch
`default_nettype wire

// File: rtl/ioctl_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ioctl_load_ctrl
//  Description : Download sequencer between hps_io's ioctl bus and the arcade
//                core. ROM bytes go to the core's download port, DIP bytes go
//                into an 8-byte switch bank. The core is held in reset until a
//                correctly sized ROM image has loaded, and for RESET_HOLD
//                cycles after every download or user reset.
//  Ports       : CLK         system clock, rising edge
//                RESET_N     asynchronous active-low reset
//                ioctl       hps_io download bus (slave side)
//                user_reset  OSD / button reset request, level-sensitive
//                dn_addr     ROM write address to the core
//                dn_data     ROM write data to the core
//                dn_wr       ROM write strobe, one cycle per accepted byte
//                dn_ld       ROM download active
//                dipsw       DIP bank, byte k on bits [8k+7:8k]
//                core_reset  active-high reset to the core
//                rom_ok      last ROM download had the correct size
//                rom_err     sticky overrun / short-image flag
//  Revision    : 1.0  initial release
// ============================================================================
module ioctl_load_ctrl
    import crazyballoon_pkg::*;
#(
    parameter int         ROM_BYTES  = 14336,
    parameter logic [7:0] ROM_INDEX  = IDX_ROM,
    parameter logic [7:0] DIP_INDEX  = IDX_DIP,
    parameter int         RESET_HOLD = 1024
) (
    input  logic               CLK,
    input  logic               RESET_N,
    ioctl_load_ctrl_if.slave   ioctl,
    input  logic               user_reset,
    output logic [15:0]        dn_addr,
    output logic [7:0]         dn_data,
    output logic               dn_wr,
    output logic               dn_ld,
    output logic [63:0]        dipsw,
    output logic               core_reset,
    output logic               rom_ok,
    output logic               rom_err
);

    localparam logic [16:0] CNT_SAT   = 17'h1_0000;
    localparam logic [16:0] CNT_FULL  = 17'(ROM_BYTES);
    localparam logic [24:0] ADDR_LIMIT = 25'(ROM_BYTES);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    load_state_t state;
    load_state_t state_nxt;
    load_state_t ret_state;     // state to fall back to after a DIP load
    logic        dl_q;          // previous ioctl_download, for edge detect
    logic [16:0] byte_cnt;      // accepted ROM bytes, saturating

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic        dl_rise;
    logic        dl_fall;
    logic        rom_rise;
    logic        dip_rise;
    logic        addr_in_rom;
    logic        rom_wr_ok;
    logic        rom_wr_bad;
    logic        dip_wr;
    logic [16:0] cnt_inc;
    logic [16:0] cnt_nxt;
    logic        err_nxt;
    logic        size_good;

    logic        rom_begin;
    logic        save_state;
    logic        stretch_start;
    logic        stretch_busy;

    assign dl_rise  =  ioctl.ioctl_download & ~dl_q;
    assign dl_fall  = ~ioctl.ioctl_download &  dl_q;
    assign rom_rise = dl_rise & (ioctl.ioctl_index == ROM_INDEX);
    assign dip_rise = dl_rise & (ioctl.ioctl_index == DIP_INDEX);

    assign addr_in_rom = (ioctl.ioctl_addr < ADDR_LIMIT);
    assign rom_wr_ok   = (state == ROM_LOAD) & ioctl.ioctl_wr &  addr_in_rom;
    assign rom_wr_bad  = (state == ROM_LOAD) & ioctl.ioctl_wr & ~addr_in_rom;
    assign dip_wr      = (state == DIP_LOAD) & ioctl.ioctl_wr &
                         (ioctl.ioctl_addr[24:3] == 22'd0);

    // The size check at the end of a ROM load includes a byte strobed in the
    // same cycle as the falling download, so it looks at the next-state
    // counter and error flag rather than the registered ones.
    assign cnt_inc   = (byte_cnt == CNT_SAT) ? byte_cnt : byte_cnt + 17'd1;
    assign cnt_nxt   = rom_wr_ok ? cnt_inc : byte_cnt;
    assign err_nxt   = rom_err | rom_wr_bad;
    assign size_good = (cnt_nxt == CNT_FULL) & ~err_nxt;

    // ------------------------------------------------------------------
    // Reset-hold counter
    // ------------------------------------------------------------------
    reset_stretch #(
        .CYCLES (RESET_HOLD)
    ) u_reset_stretch (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .start   (stretch_start),
        .busy    (stretch_busy)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= WAIT_ROM;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        rom_begin     = 1'b0;
        save_state    = 1'b0;
        stretch_start = 1'b0;

        unique case (state)
            WAIT_ROM, SETTLE, RUN: begin
                // A new download always wins, aborting any hold count.
                if (rom_rise) begin
                    state_nxt = ROM_LOAD;
                    rom_begin = 1'b1;
                end else if (dip_rise) begin
                    state_nxt  = DIP_LOAD;
                    save_state = 1'b1;
                end else if (state == SETTLE) begin
                    // Holding user_reset keeps reloading the hold count.
                    if (user_reset) begin
                        stretch_start = 1'b1;
                    end else if (!stretch_busy) begin
                        state_nxt = RUN;
                    end
                end else if ((state == RUN) && user_reset) begin
                    state_nxt     = SETTLE;
                    stretch_start = 1'b1;
                end
            end

            ROM_LOAD: begin
                if (dl_fall) begin
                    if (size_good) begin
                        state_nxt     = SETTLE;
                        stretch_start = 1'b1;
                    end else begin
                        state_nxt = WAIT_ROM;
                    end
                end
            end

            DIP_LOAD: begin
                if (dl_fall) begin
                    if (rom_ok) begin
                        state_nxt     = SETTLE;
                        stretch_start = 1'b1;
                    end else begin
                        state_nxt = ret_state;
                    end
                end
            end

            default: begin
                state_nxt = WAIT_ROM;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dl_q       <= 1'b0;
            ret_state  <= WAIT_ROM;
            byte_cnt   <= '0;
            rom_ok     <= 1'b0;
            rom_err    <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
            dn_wr      <= 1'b0;
            dn_ld      <= 1'b0;
            dipsw      <= '0;
            core_reset <= 1'b1;
        end else begin
            dl_q <= ioctl.ioctl_download;

            if (save_state) begin
                ret_state <= state;
            end

            // ROM bookkeeping
            if (rom_begin) begin
                byte_cnt <= '0;
                rom_ok   <= 1'b0;
                rom_err  <= 1'b0;
            end else if (state == ROM_LOAD) begin
                byte_cnt <= cnt_nxt;
                rom_err  <= err_nxt;
                if (dl_fall) begin
                    if (size_good) begin
                        rom_ok <= 1'b1;
                    end else begin
                        rom_err <= 1'b1;
                    end
                end
            end

            // Core download port: address/data hold their last value
            // between strobes.
            dn_wr <= rom_wr_ok;
            if (rom_wr_ok) begin
                dn_addr <= ioctl.ioctl_addr[15:0];
                dn_data <= ioctl.ioctl_dout;
            end

            if (dip_wr) begin
                dipsw[{ioctl.ioctl_addr[2:0], 3'b000} +: 8] <= ioctl.ioctl_dout;
            end

            // Both follow the current state with one register of delay.
            dn_ld      <= is_load_state(state) & (state == ROM_LOAD);
            core_reset <= (state != RUN);
        end
    end

endmodule : ioctl_load_ctrl
`default_nettype wire

// File: tb/tb_ioctl_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ioctl_load_ctrl
//  Description : Self-checking bench for ioctl_load_ctrl. Table-driven vectors
//                for the DIP and foreign-index downloads, hand-written
//                sequences for ROM loads, settle timing, user reset and
//                asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ioctl_load_ctrl;
    import crazyballoon_pkg::*;

    localparam int ROM  = 14336;
    localparam int HOLD = 1024;

    logic        clk;
    logic        rst_n;
    logic        user_reset;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        dn_ld;
    logic [63:0] dipsw;
    logic        core_reset;
    logic        rom_ok;
    logic        rom_err;

    int checks = 0;
    int errors = 0;

    ioctl_load_ctrl_if ioctl ();

    ioctl_load_ctrl #(
        .ROM_BYTES  (ROM),
        .ROM_INDEX  (IDX_ROM),
        .DIP_INDEX  (IDX_DIP),
        .RESET_HOLD (HOLD)
    ) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .ioctl      (ioctl),
        .user_reset (user_reset),
        .dn_addr    (dn_addr),
        .dn_data    (dn_data),
        .dn_wr      (dn_wr),
        .dn_ld      (dn_ld),
        .dipsw      (dipsw),
        .core_reset (core_reset),
        .rom_ok     (rom_ok),
        .rom_err    (rom_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        dl;
        logic        wr;
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        exp_cr;
        logic        exp_wr;
        logic [63:0] exp_dip;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) ^ (i >> 8));
    endfunction

    // Full ROM download of n bytes at addresses 0..n-1, back-to-back strobes.
    // Ends one tick after the falling download edge has been sampled.
    task automatic rom_download(input int n);
        int pulses;
        int mism;
        int exp_pulses;
        pulses = 0;
        mism   = 0;
        ioctl.ioctl_index    = IDX_ROM;
        ioctl.ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            ioctl.ioctl_wr   = 1'b1;
            ioctl.ioctl_addr = 25'(i);
            ioctl.ioctl_dout = pat(i);
            tick();
            if (dn_wr) begin
                pulses++;
                if (dn_addr !== 16'(i) || dn_data !== pat(i)) mism++;
            end
            if (dn_ld !== 1'b1) mism++;
        end
        ioctl.ioctl_wr       = 1'b0;
        ioctl.ioctl_download = 1'b0;
        tick();
        exp_pulses = (n < ROM) ? n : ROM;
        check("rom_wr_pulses", 64'(pulses), 64'(exp_pulses));
        check("rom_addr_data_ld", 64'(mism), 64'd0);
    endtask

    // Count ticks until core_reset drops, bounded.
    task automatic wait_release(input string name, input int exp);
        int n;
        n = 0;
        while (core_reset === 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        check(name, 64'(n), 64'(exp));
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ioctl.ioctl_download = vecs[i].dl;
            ioctl.ioctl_wr       = vecs[i].wr;
            ioctl.ioctl_index    = vecs[i].idx;
            ioctl.ioctl_addr     = vecs[i].addr;
            ioctl.ioctl_dout     = vecs[i].dout;
            tick();
            check($sformatf("vec%0d_core_reset", i), 64'(core_reset), 64'(vecs[i].exp_cr));
            check($sformatf("vec%0d_dn_wr", i),      64'(dn_wr),      64'(vecs[i].exp_wr));
            check($sformatf("vec%0d_dipsw", i),      dipsw,           vecs[i].exp_dip);
            check($sformatf("vec%0d_dn_ld", i),      64'(dn_ld),      64'd0);
        end
        ioctl.ioctl_download = 1'b0;
        ioctl.ioctl_wr       = 1'b0;
    endtask

    // Watchdog: the full run is far shorter than this.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lows;

        // DIP download in RUN, then a foreign-index download in RUN.
        //             dl    wr    idx      addr    dout   cr    wr    dipsw
        vecs[0]  = '{1'b1, 1'b0, IDX_DIP, 25'd0, 8'h00, 1'b0, 1'b0, 64'h0};
        vecs[1]  = '{1'b1, 1'b1, IDX_DIP, 25'd0, 8'hA5, 1'b1, 1'b0, 64'h00A5};
        vecs[2]  = '{1'b1, 1'b1, IDX_DIP, 25'd1, 8'h3C, 1'b1, 1'b0, 64'h3CA5};
        vecs[3]  = '{1'b1, 1'b1, IDX_DIP, 25'd8, 8'hFF, 1'b1, 1'b0, 64'h3CA5};
        vecs[4]  = '{1'b1, 1'b0, IDX_DIP, 25'd0, 8'h00, 1'b1, 1'b0, 64'h3CA5};
        vecs[5]  = '{1'b0, 1'b0, IDX_DIP, 25'd0, 8'h00, 1'b1, 1'b0, 64'h3CA5};
        vecs[6]  = '{1'b1, 1'b0, 8'd1,    25'd0, 8'h00, 1'b0, 1'b0, 64'h3CA5};
        vecs[7]  = '{1'b1, 1'b1, 8'd1,    25'd0, 8'h11, 1'b0, 1'b0, 64'h3CA5};
        vecs[8]  = '{1'b1, 1'b1, 8'd1,    25'd1, 8'h22, 1'b0, 1'b0, 64'h3CA5};
        vecs[9]  = '{1'b1, 1'b0, 8'd1,    25'd0, 8'h00, 1'b0, 1'b0, 64'h3CA5};
        vecs[10] = '{1'b0, 1'b0, 8'd1,    25'd0, 8'h00, 1'b0, 1'b0, 64'h3CA5};
        vecs[11] = '{1'b0, 1'b0, 8'd0,    25'd0, 8'h00, 1'b0, 1'b0, 64'h3CA5};

        rst_n                = 1'b0;
        user_reset           = 1'b0;
        ioctl.ioctl_download = 1'b0;
        ioctl.ioctl_wr       = 1'b0;
        ioctl.ioctl_index    = 8'd0;
        ioctl.ioctl_addr     = 25'd0;
        ioctl.ioctl_dout     = 8'd0;

        // Power-up reset values
        repeat (3) tick();
        check("rst_dn_addr",    64'(dn_addr),    64'd0);
        check("rst_dn_data",    64'(dn_data),    64'd0);
        check("rst_dn_wr",      64'(dn_wr),      64'd0);
        check("rst_dn_ld",      64'(dn_ld),      64'd0);
        check("rst_dipsw",      dipsw,           64'd0);
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_rom_ok",     64'(rom_ok),     64'd0);
        check("rst_rom_err",    64'(rom_err),    64'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        check("wait_rom_core_reset", 64'(core_reset), 64'd1);

        // Correct-size ROM image
        rom_download(ROM);
        check("full_rom_ok",  64'(rom_ok),  64'd1);
        check("full_rom_err", 64'(rom_err), 64'd0);
        check("full_dn_ld_last", 64'(dn_ld), 64'd1);
        wait_release("full_release_delay", HOLD + 1);
        tick();
        check("full_dn_ld_idle", 64'(dn_ld), 64'd0);

        // DIP download while running
        apply_vecs(0, 5);
        wait_release("dip_release_delay", HOLD + 1);

        // user_reset pulse of 5 cycles
        user_reset = 1'b1;
        tick();
        check("ureset_cr_first", 64'(core_reset), 64'd0);
        tick();
        check("ureset_cr_rise", 64'(core_reset), 64'd1);
        repeat (3) tick();
        user_reset = 1'b0;
        wait_release("ureset_release_delay", HOLD + 1);

        // Foreign index while running: ignored
        apply_vecs(6, 11);

        // Oversized image: two extra bytes
        rom_download(ROM + 2);
        check("over_rom_err", 64'(rom_err), 64'd1);
        check("over_rom_ok",  64'(rom_ok),  64'd0);
        lows = 0;
        for (int i = 0; i < HOLD + 100; i++) begin
            tick();
            if (core_reset !== 1'b1) lows++;
        end
        check("over_core_reset_held", 64'(lows), 64'd0);

        // Asynchronous reset in the middle of a ROM download
        ioctl.ioctl_index    = IDX_ROM;
        ioctl.ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 5000; i++) begin
            ioctl.ioctl_wr   = 1'b1;
            ioctl.ioctl_addr = 25'(i);
            ioctl.ioctl_dout = pat(i);
            tick();
        end
        check("pre_rst_dn_wr", 64'(dn_wr), 64'd1);
        ioctl.ioctl_addr = 25'd5000;
        ioctl.ioctl_dout = pat(5000);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_dn_addr",    64'(dn_addr),    64'd0);
        check("arst_dn_data",    64'(dn_data),    64'd0);
        check("arst_dn_wr",      64'(dn_wr),      64'd0);
        check("arst_dn_ld",      64'(dn_ld),      64'd0);
        check("arst_dipsw",      dipsw,           64'd0);
        check("arst_core_reset", 64'(core_reset), 64'd1);
        check("arst_rom_err",    64'(rom_err),    64'd0);
        ioctl.ioctl_wr       = 1'b0;
        ioctl.ioctl_download = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("arst_wait_rom", 64'(core_reset), 64'd1);

        rom_download(ROM);
        check("reload_rom_ok",  64'(rom_ok),  64'd1);
        check("reload_rom_err", 64'(rom_err), 64'd0);
        wait_release("reload_release_delay", HOLD + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ioctl_load_ctrl
`default_nettype wire
